// File: rtl/adc_frame_packer.sv
// Packs each 8-channel ADC sample set into a frame of 32-bit RAM words inside a ping-pong buffer.
// Define ADC_FRAME_HDR_EN to prefix every frame with a {16'hA5A5, frame_cnt} header word.
module adc_frame_packer #(
    parameter int ADDR_WIDTH      = 14,
    parameter int FRAMES_PER_HALF = 1024
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  adc_enable,
    input  logic                  adc_read_done,
    input  logic [15:0]           adc_ch1,
    input  logic [15:0]           adc_ch2,
    input  logic [15:0]           adc_ch3,
    input  logic [15:0]           adc_ch4,
    input  logic [15:0]           adc_ch5,
    input  logic [15:0]           adc_ch6,
    input  logic [15:0]           adc_ch7,
    input  logic [15:0]           adc_ch8,
    input  logic [1:0]            buf_ack,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  mem_wr_en,
    output logic [1:0]            buf_ready,
    output logic                  buf_overflow,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

`ifdef ADC_FRAME_HDR_EN
    localparam int WPF = 5;
`else
    localparam int WPF = 4;
`endif
    localparam int                    HALF_WORDS  = FRAMES_PER_HALF * WPF;
    localparam logic [ADDR_WIDTH-1:0] HALF_BASE   = ADDR_WIDTH'(HALF_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(HALF_WORDS - 1);
    localparam logic [2:0]            LAST_WORD   = 3'(WPF - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state, state_nxt;
    logic                    en_q;
    logic                    en_rise;
    logic                    frame_req;
    logic                    accept;
    logic                    drop;
    logic                    last_word;
    logic                    half_full;
    logic                    wr_half;
    logic [ADDR_WIDTH-1:0]   wr_offset;
    logic [2:0]              word_idx;
    logic [1:0]              pair;
    logic [1:0]              ready_set;
    logic [15:0]             shadow [8];

    // An enable rising edge restarts the capture session and swallows a coincident strobe.
    assign en_rise   = adc_enable & ~en_q;
    assign frame_req = adc_read_done & adc_enable & ~en_rise;
    assign half_full = last_word && (wr_offset == LAST_OFFSET);
    assign ready_set = half_full ? (2'b01 << wr_half) : 2'b00;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        mem_wr_en = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;
        last_word = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req) begin
                    if (buf_ready[wr_half]) begin
                        drop = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                busy      = 1'b1;
                drop      = frame_req;
                if (word_idx == LAST_WORD) begin
                    last_word = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the eight shadow registers are reset like any other flop; they are not a RAM macro.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (accept) begin
            shadow[0] <= adc_ch1;
            shadow[1] <= adc_ch2;
            shadow[2] <= adc_ch3;
            shadow[3] <= adc_ch4;
            shadow[4] <= adc_ch5;
            shadow[5] <= adc_ch6;
            shadow[6] <= adc_ch7;
            shadow[7] <= adc_ch8;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            word_idx     <= '0;
            wr_half      <= 1'b0;
            wr_offset    <= '0;
            buf_ready    <= '0;
            buf_overflow <= 1'b0;
            drop_cnt     <= '0;
            frame_cnt    <= '0;
        end else begin
            en_q <= adc_enable;

            if (mem_wr_en) word_idx <= last_word ? 3'd0 : word_idx + 3'd1;

            if (en_rise) begin
                wr_half   <= 1'b0;
                wr_offset <= '0;
            end else if (mem_wr_en) begin
                if (half_full) begin
                    wr_half   <= ~wr_half;
                    wr_offset <= '0;
                end else begin
                    wr_offset <= wr_offset + 1'b1;
                end
            end

            if (en_rise)        frame_cnt <= '0;
            else if (last_word) frame_cnt <= frame_cnt + 16'd1;

            // Setting a half's ready flag overrides a simultaneous ack of that half.
            if (en_rise) buf_ready <= '0;
            else         buf_ready <= (buf_ready & ~buf_ack) | ready_set;

            // A drop overrides a simultaneous clear: the lost frame is the first one counted.
            if (en_rise) begin
                buf_overflow <= 1'b0;
                drop_cnt     <= '0;
            end else if (drop) begin
                buf_overflow <= 1'b1;
                if (ovf_clr)                    drop_cnt <= 16'd1;
                else if (drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
            end else if (ovf_clr) begin
                buf_overflow <= 1'b0;
                drop_cnt     <= '0;
            end
        end
    end

    assign mem_wr_addr = (wr_half ? HALF_BASE : '0) + wr_offset;

`ifdef ADC_FRAME_HDR_EN
    assign pair = word_idx[1:0] - 2'd1;
`else
    assign pair = word_idx[1:0];
`endif

    always_comb begin
        mem_wr_data = '0;
        if (mem_wr_en) begin
`ifdef ADC_FRAME_HDR_EN
            if (word_idx == 3'd0) mem_wr_data = {16'hA5A5, frame_cnt};
            else                  mem_wr_data = {shadow[{pair, 1'b1}], shadow[{pair, 1'b0}]};
`else
            mem_wr_data = {shadow[{pair, 1'b1}], shadow[{pair, 1'b0}]};
`endif
        end
    end

endmodule
